mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder serving load/store requests from the processor datapath.
- Accepts one request at a time over a valid/ready handshake: byte address, write enable, write data and the 2-bit memory selector.
- Services the request after a programmable number of wait cycles from an internal word RAM or a small IO register bank.
- Returns read data over a valid/ready response channel; lets the team model slow memory ahead of a multi-cycle core.

Parameters:
- DEPTH, 256, number of 32-bit words in the data RAM (power of two).
- WAIT_CYCLES, 2, extra cycles between request accept and response (0 allowed).
- IO_REGS, 4, number of 32-bit IO registers (power of two, max 16).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_wdata  in  32  store data.
- req_sel  in  2  memory selector: 00 RAM, 01 IO bank, 10/11 reserved.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  initiator takes the response.
- rsp_rdata  out  32  load data; 0 for stores.
- io_out  out  32  live value of IO register 0 (board LEDs/display).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, io_out=0, all IO registers=0, wait counter=0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1.
  - On req_valid at a rising edge: latch we/addr/wdata/sel.
  - Go to WAIT with counter=WAIT_CYCLES-1, or directly to ACCESS if WAIT_CYCLES=0.
- ACCESS is the internal one-edge action at WAIT expiry (counter==0):
  - Perform the RAM/IO read or write exactly once.
  - Register the read result into rsp_rdata, then go to RESP.
- Latency: rsp_valid rises exactly WAIT_CYCLES+1 edges after the accepting edge.
- WAIT, RESP: req_ready=0. req_valid is ignored and does not queue.
- RESP: rsp_valid=1, rsp_rdata stable. Stay until rsp_ready=1 at an edge, then IDLE. req_ready returns 1 one cycle later; no same-cycle re-accept.
- RAM decode: word index = req_addr[log2(DEPTH)+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH*4.
- IO decode: index = req_addr[log2(IO_REGS)+1:2]. Stores update the register; loads return it.
- Reserved sel (10/11): stores dropped, loads return 0.
- Stores return rsp_rdata=0.
- io_out reflects IO reg 0 from the edge after it is written.
- Reset asserted mid-WAIT or mid-RESP: the pending transaction is discarded and no write commits if ACCESS had not yet occurred.
- rsp_ready held high while idle has no effect.

Optional Feature:
- Macro MEM_RESPONDER_ERR_EN.
- When defined:
  - Adds output rsp_err (1 bit, reset 0, valid with rsp_valid).
  - rsp_err=1 for a reserved sel, or for a RAM address with any bit above log2(DEPTH)+1 set. The write is suppressed and rdata=0.
- When undefined: no rsp_err port; addresses wrap and reserved selectors behave silently as above.

Decomposition:
- Package mem_responder_pkg holds:
  - state enum (IDLE, WAIT, RESP);
  - selector constants SEL_RAM=2'b00, SEL_IO=2'b01;
  - word width constant 32.
- Sub-module mem_responder_ram: single-port synchronous RAM, DEPTH x 32, write-enable and registered read, no reset.
- FSM, counter, IO bank and response register live in the top module.

Test Plan:
- Reset → req_ready=1, rsp_valid=0, io_out=0. Store sel=00 addr=0x10 data=0xDEADBEEF, then load addr=0x10 → rsp_rdata=0xDEADBEEF. rsp_valid rises exactly 3 edges after accept (WAIT_CYCLES=2).
- Store sel=01 addr=0x0 data=0x0000_00A5 → io_out=0x000000A5 after ACCESS. Load sel=01 addr=0x0 → 0xA5. Load sel=01 addr=0x4 → 0.
- Wrap: store RAM addr=0x400 data=0x1234 (DEPTH=256), load addr=0x0 → 0x1234. With MEM_RESPONDER_ERR_EN: the same store gets rsp_err=1 and a later load of addr=0x0 returns the prior value.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stable and req_ready=0. A req_valid pulse during this window is not accepted.
- Reset during WAIT of a store to addr=0x20 → state IDLE, no rsp_valid, and a later load of 0x20 returns the old value.
- Reserved sel=11: load → rsp_rdata=0, store → no RAM/IO change (rsp_err=1 when the feature is enabled).

Source files
------------

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared types and constants for the memory responder.
// Contents: FSM state enum, memory selector codes, data word width.
package mem_responder_pkg;
   localparam int WORD_W = 32;
   localparam logic [1:0] SEL_RAM = 2'b00;
   localparam logic [1:0] SEL_IO  = 2'b01;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
endpackage

// File: rtl/mem_responder_ram.sv
// mem_responder_ram: single-port synchronous word RAM, registered read, no reset.
// Ports: clk_i clock, we_i write enable, addr_i word index, wdata_i write data,
//        rdata_o read data of addr_i from the previous edge (read-first).
module mem_responder_ram
   import mem_responder_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o
);
   logic [WORD_W-1:0] mem_q [DEPTH];
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      rdata_o <= mem_q[addr_i];
   end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: one-at-a-time load/store responder with programmable wait cycles.
// Ports: clk_i clock, rst_ni async active-low reset,
//        req_valid_i/req_ready_o request handshake, req_we_i store flag,
//        req_addr_i byte address, req_wdata_i store data, req_sel_i 00 RAM / 01 IO,
//        rsp_valid_o/rsp_ready_i response handshake, rsp_rdata_o load data,
//        io_out_o live IO register 0, rsp_err_o (only with MEM_RESPONDER_ERR_EN).
// Optional: MEM_RESPONDER_ERR_EN flags reserved selectors and out-of-range RAM addresses.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2,
   parameter int IO_REGS     = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [31:0]       req_addr_i,
   input  logic [WORD_W-1:0] req_wdata_i,
   input  logic [1:0]        req_sel_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [WORD_W-1:0] rsp_rdata_o,
`ifdef MEM_RESPONDER_ERR_EN
   output logic              rsp_err_o,
`endif
   output logic [WORD_W-1:0] io_out_o
);
   localparam int RAW = $clog2(DEPTH);
   localparam int IOW = (IO_REGS > 1) ? $clog2(IO_REGS) : 1;
   localparam int CW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              we_q;
   logic [1:0]        sel_q;
   logic [RAW-1:0]    ram_idx_q;
   logic [IOW-1:0]    io_idx_q;
   logic [WORD_W-1:0] wdata_q, rdata_q, rdata_d, ram_rdata;
   logic [WORD_W-1:0] io_q [IO_REGS];
   logic              accept, access, blk, ram_we, io_we;
   logic              unused_bits;

   assign accept      = (state_q == IDLE) && req_valid_i;
   assign access      = (state_q == WAIT) && (cnt_q == '0);
   assign unused_bits = ^{req_addr_i[31:RAW+2], req_addr_i[1:0]};

`ifdef MEM_RESPONDER_ERR_EN
   logic err_q;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) err_q <= 1'b0;
      else if (accept) err_q <= req_sel_i[1] || (req_sel_i == SEL_RAM && |req_addr_i[31:RAW+2]);
   end
   assign blk       = err_q;
   assign rsp_err_o = (state_q == RESP) && err_q;
`else
   assign blk = 1'b0;
`endif

   // While idle the RAM reads the incoming address so its registered output
   // is already valid at the ACCESS edge, even when WAIT_CYCLES is 0.
   mem_responder_ram #(.DEPTH(DEPTH)) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .addr_i  ((state_q == IDLE) ? req_addr_i[RAW+1:2] : ram_idx_q),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid_i) state_d = WAIT;
         WAIT:    if (cnt_q == '0) state_d = RESP;
         RESP:    if (rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = (state_q == IDLE);
      rsp_valid_o = (state_q == RESP);
   end

   // Counter is loaded with WAIT_CYCLES so ACCESS lands WAIT_CYCLES+1 edges after accept.
   always_comb begin
      ram_we  = access && we_q && !blk && (sel_q == SEL_RAM);
      io_we   = access && we_q && !blk && (sel_q == SEL_IO);
      cnt_d   = accept ? CW'(WAIT_CYCLES) : (state_q == WAIT && cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
      rdata_d = !access ? rdata_q :
                (we_q || blk) ? '0 :
                (sel_q == SEL_RAM) ? ram_rdata :
                (sel_q == SEL_IO) ? io_q[io_idx_q] : '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         rdata_q   <= '0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         ram_idx_q <= '0;
         io_idx_q  <= '0;
         wdata_q   <= '0;
         io_q      <= '{default: '0};
      end else begin
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         if (accept) begin
            we_q      <= req_we_i;
            sel_q     <= req_sel_i;
            ram_idx_q <= req_addr_i[RAW+1:2];
            io_idx_q  <= req_addr_i[IOW+1:2];
            wdata_q   <= req_wdata_i;
         end
         if (io_we) io_q[io_idx_q] <= wdata_q;
      end
   end

   assign rsp_rdata_o = rdata_q;
   assign io_out_o    = io_q[0];
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench with a cycle-level reference model of mem_responder.
module tb_mem_responder;
   localparam int DEPTH = 256;
   localparam int WAITC = 2;
   localparam int IOR   = 4;
`ifdef MEM_RESPONDER_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   logic        clk = 1'b0, rst_n = 1'b0, req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [1:0]  req_sel = '0;
   logic        req_ready, rsp_valid;
   logic [31:0] rsp_rdata, io_out;
`ifdef MEM_RESPONDER_ERR_EN
   logic        rsp_err;
`endif
   int n_cmp = 0, n_bad = 0;

   mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC), .IO_REGS(IOR)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .req_sel_i   (req_sel),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata),
`ifdef MEM_RESPONDER_ERR_EN
      .rsp_err_o   (rsp_err),
`endif
      .io_out_o    (io_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a request is answered WAIT_CYCLES+1 edges after it is taken,
   // memory effects happen on the edge the answer appears.
   logic        m_busy, m_we, m_err, m_known;
   int          m_left;
   logic [31:0] m_a, m_d, m_rd;
   logic [1:0]  m_sel;
   logic [31:0] ram_m [DEPTH];
   bit          ram_k [DEPTH];
   logic [31:0] io_m [IOR];
   int          ram_i, io_i;
   assign ram_i = int'((m_a >> 2) % DEPTH);
   assign io_i  = int'((m_a >> 2) % IOR);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  <= 1'b0;
         m_left  <= 0;
         m_rd    <= '0;
         m_err   <= 1'b0;
         m_known <= 1'b1;
         for (int i = 0; i < IOR; i++) io_m[i] <= '0;
      end else if (!m_busy) begin
         if (req_valid) begin
            m_busy  <= 1'b1;
            m_left  <= WAITC + 1;
            m_we    <= req_we;
            m_a     <= req_addr;
            m_d     <= req_wdata;
            m_sel   <= req_sel;
            m_known <= 1'b1;
            m_err   <= ERR && (req_sel > 2'd1 || (req_sel == 2'd0 && req_addr >= 32'(DEPTH * 4)));
         end
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            if (m_we || m_err || m_sel > 2'd1) m_rd <= '0;
            else if (m_sel == 2'd0) begin
               m_rd    <= ram_m[ram_i];
               m_known <= ram_k[ram_i];
            end else m_rd <= io_m[io_i];
            if (m_we && !m_err && m_sel == 2'd0) begin
               ram_m[ram_i] <= m_d;
               ram_k[ram_i] <= 1'b1;
            end
            if (m_we && !m_err && m_sel == 2'd1) io_m[io_i] <= m_d;
         end
      end else if (rsp_ready) m_busy <= 1'b0;
   end

   always @(negedge clk) begin
      check("req_ready", {31'b0, req_ready}, {31'b0, !m_busy});
      check("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_busy && m_left == 0});
      check("io_out", io_out, io_m[0]);
      if (m_busy && m_left == 0 && m_known) check("rsp_rdata", rsp_rdata, m_rd);
`ifdef MEM_RESPONDER_ERR_EN
      check("rsp_err", {31'b0, rsp_err}, {31'b0, m_busy && m_left == 0 && m_err});
`endif
   end

   task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                       input int hold, input logic [31:0] exp, output logic err);
      int lat;
      logic [31:0] held;
      req_we = we; req_addr = a; req_wdata = d; req_sel = s; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1 lat++;
      end
      check("latency", lat, WAITC + 1);
      check("rdata_lit", rsp_rdata, exp);
`ifdef MEM_RESPONDER_ERR_EN
      err = rsp_err;
`else
      err = 1'b0;
`endif
      held = rsp_rdata;
      for (int i = 0; i < hold; i++) begin
         if (i == 1) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h44; req_sel = 2'd0;
         end
         if (i == 2) req_valid = 1'b0;
         @(posedge clk); #1;
         check("hold_valid", {31'b0, rsp_valid}, 32'd1);
         check("hold_rdata", rsp_rdata, held);
         check("hold_ready", {31'b0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1 rsp_ready = 1'b0;
      check("post_ready", {31'b0, req_ready}, 32'd1);
      check("post_valid", {31'b0, rsp_valid}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic e;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", {31'b0, req_ready}, 32'd1);
      check("rst_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_io", io_out, 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      xfer(1'b1, 32'h10, 32'hDEADBEEF, 2'd0, 0, 32'd0, e);
      xfer(1'b0, 32'h10, 32'd0, 2'd0, 0, 32'hDEADBEEF, e);

      xfer(1'b1, 32'h0, 32'h000000A5, 2'd1, 0, 32'd0, e);
      check("io_lit", io_out, 32'h000000A5);
      xfer(1'b0, 32'h0, 32'd0, 2'd1, 0, 32'h000000A5, e);
      xfer(1'b0, 32'h4, 32'd0, 2'd1, 0, 32'd0, e);

      xfer(1'b1, 32'h0, 32'h00005555, 2'd0, 0, 32'd0, e);
      xfer(1'b1, 32'h400, 32'h00001234, 2'd0, 0, 32'd0, e);
      check("wrap_err", {31'b0, e}, {31'b0, ERR});
      xfer(1'b0, 32'h0, 32'd0, 2'd0, 0, ERR ? 32'h00005555 : 32'h00001234, e);

      xfer(1'b0, 32'h10, 32'd0, 2'd0, 5, 32'hDEADBEEF, e);
      repeat (WAITC + 3) @(posedge clk);
      #1 check("no_queue", {31'b0, rsp_valid}, 32'd0);

      xfer(1'b1, 32'h20, 32'h11111111, 2'd0, 0, 32'd0, e);
      req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h00000099; req_sel = 2'd0; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      check("midrst_ready", {31'b0, req_ready}, 32'd1);
      check("midrst_valid", {31'b0, rsp_valid}, 32'd0);
      check("midrst_io", io_out, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (WAITC + 3) @(posedge clk);
      #1 check("midrst_quiet", {31'b0, rsp_valid}, 32'd0);
      xfer(1'b0, 32'h20, 32'd0, 2'd0, 0, 32'h11111111, e);

      xfer(1'b1, 32'h0, 32'h0000003C, 2'd1, 0, 32'd0, e);
      xfer(1'b0, 32'h10, 32'd0, 2'd3, 0, 32'd0, e);
      check("rsv_ld_err", {31'b0, e}, {31'b0, ERR});
      xfer(1'b1, 32'h10, 32'h0000CAFE, 2'd3, 0, 32'd0, e);
      xfer(1'b1, 32'h0, 32'h0000BEEF, 2'd2, 0, 32'd0, e);
      check("rsv_io_kept", io_out, 32'h0000003C);
      xfer(1'b0, 32'h10, 32'd0, 2'd0, 0, 32'hDEADBEEF, e);
      xfer(1'b0, 32'h0, 32'd0, 2'd1, 0, 32'h0000003C, e);

      rsp_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1 rsp_ready = 1'b0;
      check("idle_rdy_valid", {31'b0, rsp_valid}, 32'd0);
      check("idle_rdy_ready", {31'b0, req_ready}, 32'd1);

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
